instr_fetch_stage: RTL and testbench

Fetch stage between `program_counter` and decode. Fetches the instruction at the current `pc` over a req/ack instruction-memory port and holds `busy` high toward `program_counter` until the word is captured. Presents `{if_pc, if_instr, if_valid}` to decode through the IF/ID register, and honours decode `stall` and control-flow `flush`. Detects misaligned PCs and memory-ack timeouts as a sticky fault.

---
 rtl/instr_fetch_stage.sv | 128 ++++++++++++
 tb/tb_instr_fetch_stage.sv | 153 +++++++++++++++
 2 files changed

// File: rtl/instr_fetch_stage.sv
// Instruction fetch stage: req/ack fetch of the current PC into a one-word
// buffer, then hand-off to decode through the IF/ID register.
module instr_fetch_stage #(
   parameter logic [31:0] NOP_INSTR   = 32'h0000_0000,
   parameter int          ACK_TIMEOUT = 255
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic [31:0] pc,
   input  logic        stall,
   input  logic        flush,
   output logic        busy,
   output logic        mem_req,
   output logic [31:0] mem_addr,
   input  logic        mem_ack,
   input  logic [31:0] mem_rdata,
   output logic        if_valid,
   output logic [31:0] if_pc,
   output logic [31:0] if_instr,
   output logic        fault
);

   typedef enum logic [1:0] {IDLE, REQ, DONE, FAULT} state_t;

   typedef struct packed {
      logic        valid;
      logic [31:0] pc;
      logic [31:0] instr;
   } ifid_t;

   localparam logic [15:0] TMO_LAST = 16'(ACK_TIMEOUT - 1);

   state_t      state, state_nxt;
   logic [15:0] tmo_cnt, tmo_cnt_nxt;
   logic [31:0] buf_pc, buf_instr;
   logic        capture;
   logic        aligned;
   ifid_t       ifid, ifid_nxt;

   assign aligned = (pc[1:0] == 2'b00);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state   <= IDLE;
         tmo_cnt <= '0;
      end else begin
         state   <= state_nxt;
         tmo_cnt <= tmo_cnt_nxt;
      end
   end

   // A misaligned PC wins over everything, including flush and a stray ack.
   always_comb begin
      state_nxt   = state;
      tmo_cnt_nxt = tmo_cnt;
      capture     = 1'b0;
      case (state)
         IDLE:  state_nxt = REQ;
         REQ: begin
            if (!aligned) begin
               state_nxt = FAULT;
            end else if (flush) begin
               tmo_cnt_nxt = '0;
            end else if (mem_ack) begin
               capture     = 1'b1;
               tmo_cnt_nxt = '0;
               state_nxt   = DONE;
            end else if (tmo_cnt == TMO_LAST) begin
               state_nxt = FAULT;
            end else begin
               tmo_cnt_nxt = tmo_cnt + 16'd1;
            end
         end
         DONE: begin
            if (flush || !stall) state_nxt = REQ;
         end
         FAULT: state_nxt = FAULT;
         default: state_nxt = IDLE;
      endcase
   end

   assign busy     = (state != DONE);
   assign mem_req  = (state == REQ) && aligned;
   assign mem_addr = pc;
   assign fault    = (state == FAULT);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         buf_pc    <= '0;
         buf_instr <= NOP_INSTR;
      end else if (capture) begin
         buf_pc    <= pc;
         buf_instr <= mem_rdata;
      end
   end

   // IF/ID: load on leaving DONE, bubble when nothing to give or on flush,
   // otherwise hold while decode stalls.
   always_comb begin
      ifid_nxt = ifid;
      if (state == FAULT) begin
         ifid_nxt.valid = 1'b0;
         if (!stall) ifid_nxt.instr = NOP_INSTR;
      end else if (state == DONE && !flush && !stall) begin
         ifid_nxt.valid = 1'b1;
         ifid_nxt.pc    = buf_pc;
         ifid_nxt.instr = buf_instr;
      end else if (flush || (state != DONE && !stall)) begin
         ifid_nxt.valid = 1'b0;
         ifid_nxt.instr = NOP_INSTR;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         ifid.valid <= 1'b0;
         ifid.pc    <= '0;
         ifid.instr <= NOP_INSTR;
      end else begin
         ifid <= ifid_nxt;
      end
   end

   assign if_valid = ifid.valid;
   assign if_pc    = ifid.pc;
   assign if_instr = ifid.instr;

endmodule

// File: tb/tb_instr_fetch_stage.sv
// Randomized bench for instr_fetch_stage against a transaction-level model
// of the fetch/hand-off rules; the bench also plays program_counter.
module tb_instr_fetch_stage;

   localparam logic [31:0] NOP = 32'h0000_0013;
   localparam int          TMO = 4;

   logic        clk = 1'b0, rst_n = 1'b0;
   logic        stall = 1'b0, flush = 1'b0, mem_ack = 1'b0;
   logic [31:0] pc = '0, mem_rdata = '0;
   logic        busy, mem_req, if_valid, fault;
   logic [31:0] mem_addr, if_pc, if_instr;

   instr_fetch_stage #(.NOP_INSTR(NOP), .ACK_TIMEOUT(TMO)) dut (
      .clk(clk), .rst_n(rst_n), .pc(pc), .stall(stall), .flush(flush),
      .busy(busy), .mem_req(mem_req), .mem_addr(mem_addr),
      .mem_ack(mem_ack), .mem_rdata(mem_rdata),
      .if_valid(if_valid), .if_pc(if_pc), .if_instr(if_instr), .fault(fault)
   );

   always #5 clk = ~clk;

   int n_vec = 0, n_err = 0;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_vec++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %h expected %h (t=%0t)", tag, got, exp, $time);
      end
   endtask

   // Model: started = left the post-reset cycle, have_word = a fetched word
   // waits for decode, misses = consecutive ack-less cycles of this request.
   bit          started, have_word, dead;
   int          misses;
   logic [31:0] w_pc, w_instr;
   bit          e_valid;
   logic [31:0] e_pc, e_instr;

   task automatic model_reset();
      started = 0; have_word = 0; dead = 0; misses = 0;
      w_pc = '0; w_instr = NOP;
      e_valid = 0; e_pc = '0; e_instr = NOP;
   endtask

   task automatic check_outputs();
      bit exp_req;
      exp_req = started && !have_word && !dead && (pc[1:0] == 2'b00);
      chk("busy",     32'(busy),     32'(!have_word));
      chk("mem_req",  32'(mem_req),  32'(exp_req));
      if (exp_req) chk("mem_addr", mem_addr, pc);
      chk("fault",    32'(fault),    32'(dead));
      chk("if_valid", 32'(if_valid), 32'(e_valid));
      chk("if_pc",    if_pc,         e_pc);
      chk("if_instr", if_instr,      e_instr);
   endtask

   // Called at a negedge; returns at the following negedge.
   task automatic step(input int ack_pct, input int stall_pct, input int flush_pct);
      logic [31:0] tgt, pc_next;
      bit bubble;
      stall     = ($urandom_range(0, 99) < stall_pct);
      flush     = ($urandom_range(0, 99) < flush_pct);
      mem_ack   = ($urandom_range(0, 99) < ack_pct);
      mem_rdata = $urandom;
      tgt       = $urandom;
      tgt[1:0]  = ($urandom_range(0, 39) == 0) ? 2'b10 : 2'b00;
      #1;
      check_outputs();

      // program_counter: jump on flush, advance when fetch done and accepted
      if (flush)                    pc_next = tgt;
      else if (have_word && !stall) pc_next = pc + 32'd4;
      else                          pc_next = pc;

      bubble = flush || !stall;
      if (dead) begin
         e_valid = 0;
         if (!stall) e_instr = NOP;
      end else if (!started) begin
         started = 1;
         if (bubble) begin e_valid = 0; e_instr = NOP; end
      end else if (have_word) begin
         if (flush) begin
            have_word = 0; e_valid = 0; e_instr = NOP;
         end else if (!stall) begin
            have_word = 0; e_valid = 1; e_pc = w_pc; e_instr = w_instr;
         end
      end else begin
         if (bubble) begin e_valid = 0; e_instr = NOP; end
         if (pc[1:0] != 2'b00) dead = 1;
         else if (flush) misses = 0;
         else if (mem_ack) begin
            have_word = 1; w_pc = pc; w_instr = mem_rdata; misses = 0;
         end else begin
            misses++;
            if (misses == TMO) dead = 1;
         end
      end

      @(posedge clk);
      #1 pc = pc_next;
      @(negedge clk);
   endtask

   // Asynchronous reset asserted between edges, released at a negedge.
   task automatic do_reset(input logic [31:0] start_pc);
      #2 rst_n = 1'b0;
      #1;
      model_reset();
      check_outputs();
      @(posedge clk);
      #1 check_outputs();
      @(negedge clk);
      pc = start_pc;
      rst_n = 1'b1;
   endtask

   initial begin
      logic [31:0] spc;
      model_reset();
      @(negedge clk);
      do_reset(32'h8002_0000);
      // zero-wait, no stall, no flush
      repeat (12) step(100, 0, 0);
      // slow memory within the timeout, stalls, no flush
      do_reset(32'h8002_0004);
      repeat (30) step(60, 40, 0);
      // misaligned start PC
      do_reset(32'h8002_0002);
      repeat (6) step(100, 0, 0);
      // starved memory hits the timeout
      do_reset(32'h8000_0100);
      repeat (10) step(0, 0, 0);
      for (int ep = 0; ep < 40; ep++) begin
         spc = $urandom;
         spc[1:0] = 2'b00;
         do_reset(spc);
         repeat (60) step($urandom_range(20, 100), $urandom_range(0, 60),
                          $urandom_range(0, 20));
      end
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

   initial begin
      #2_000_000;
      $display("FAIL watchdog: got timeout expected completion");
      $fatal(1, "watchdog");
   end

endmodule
